// File: rtl/dbd_pkg.sv
// Shared types and helpers for the double-buffered vector drain.
package dbd_pkg;

  typedef enum logic {RD_IDLE, RD_STREAM} rd_state_t;

  localparam int unsigned VEC_CNT_W = 16;

  // Element index width; a single-element vector still needs one index bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dbd_bank.sv
// One vector bank: whole-vector parallel load, single-element read mux.
module dbd_bank #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned MATRIX_SIZE = 3,
  parameter int unsigned IDX_W       = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load_en,
  input  logic [DATA_WIDTH*MATRIX_SIZE-1:0] load_flat,
  input  logic [IDX_W-1:0]                sel,
  output logic [DATA_WIDTH-1:0]           elem
);

  logic [DATA_WIDTH-1:0] mem [MATRIX_SIZE];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < MATRIX_SIZE; i++) mem[i] <= '0;
    end else if (load_en) begin
      for (int unsigned i = 0; i < MATRIX_SIZE; i++)
        mem[i] <= load_flat[DATA_WIDTH*i +: DATA_WIDTH];
    end
  end

  // Compare-based mux keeps out-of-range index codes reading zero.
  always_comb begin
    elem = '0;
    for (int unsigned i = 0; i < MATRIX_SIZE; i++)
      if (sel == IDX_W'(i)) elem = mem[i];
  end

endmodule

// File: rtl/double_buffer_drain.sv
// Ping-pong vector capture drained as a serial element stream.
// Optional DBD_VEC_COUNT_EN adds a 16-bit drained-vector counter output.
module double_buffer_drain
  import dbd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned MATRIX_SIZE = 3,
  localparam int unsigned IDX_W      = idx_w(MATRIX_SIZE)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              vec_valid,
  output logic                              vec_ready,
  input  logic [DATA_WIDTH*MATRIX_SIZE-1:0] vec_in_flat,
  output logic                              elem_valid,
  input  logic                              elem_ready,
  output logic [DATA_WIDTH-1:0]             elem_data,
  output logic [IDX_W-1:0]                  elem_idx,
  output logic                              elem_last,
  output logic                              busy
`ifdef DBD_VEC_COUNT_EN
  ,
  output logic [VEC_CNT_W-1:0]              vec_count
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MATRIX_SIZE - 1);

  rd_state_t             state, state_nxt;
  logic [1:0]            full;
  logic                  wr_ptr, rd_ptr;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] bank_elem [2];
  logic                  capture, xfer, xfer_last;

  assign vec_ready = !full[wr_ptr];
  assign capture   = vec_valid && vec_ready;
  assign busy      = |full;
  assign elem_idx  = idx;
  assign xfer      = elem_valid && elem_ready;
  assign xfer_last = xfer && elem_last;

  dbd_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .MATRIX_SIZE(MATRIX_SIZE),
    .IDX_W      (IDX_W)
  ) u_bank0 (
    .clk      (clk),
    .rst      (rst),
    .load_en  (capture && !wr_ptr),
    .load_flat(vec_in_flat),
    .sel      (idx),
    .elem     (bank_elem[0])
  );

  dbd_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .MATRIX_SIZE(MATRIX_SIZE),
    .IDX_W      (IDX_W)
  ) u_bank1 (
    .clk      (clk),
    .rst      (rst),
    .load_en  (capture && wr_ptr),
    .load_flat(vec_in_flat),
    .sel      (idx),
    .elem     (bank_elem[1])
  );

  always_comb begin
    state_nxt  = state;
    elem_valid = 1'b0;
    elem_data  = '0;
    elem_last  = 1'b0;
    case (state)
      RD_IDLE: begin
        if (full[rd_ptr]) state_nxt = RD_STREAM;
      end
      RD_STREAM: begin
        elem_valid = 1'b1;
        elem_data  = bank_elem[rd_ptr];
        elem_last  = (idx == LAST_IDX);
        // Back-to-back vectors continue without a bubble.
        if (elem_ready && elem_last && !full[~rd_ptr]) state_nxt = RD_IDLE;
      end
      default: state_nxt = RD_IDLE;
    endcase
  end

  // Capture and final drain always touch different banks, so both flag updates land.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RD_IDLE;
      full   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      idx    <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        full[wr_ptr] <= 1'b1;
        wr_ptr       <= ~wr_ptr;
      end
      if (xfer_last) begin
        full[rd_ptr] <= 1'b0;
        rd_ptr       <= ~rd_ptr;
        idx          <= '0;
      end else if (xfer) begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

`ifdef DBD_VEC_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)            vec_count <= '0;
    else if (xfer_last) vec_count <= vec_count + VEC_CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_double_buffer_drain.sv
// Scoreboard bench for double_buffer_drain: directed vectors, queued expectations.
module tb_double_buffer_drain;

  localparam int DW = 8;
  localparam int MS = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           vec_valid;
  logic           vec_ready;
  logic [DW*MS-1:0] vec_in_flat;
  logic           elem_valid;
  logic           elem_ready;
  logic [DW-1:0]  elem_data;
  logic [1:0]     elem_idx;
  logic           elem_last;
  logic           busy;
`ifdef DBD_VEC_COUNT_EN
  logic [15:0]    vec_count;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] idx;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  exp_t front;
  int   xfer_edges[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cap_edge = 0;
  int   c3 = 0;

  double_buffer_drain #(
    .DATA_WIDTH (DW),
    .MATRIX_SIZE(MS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vec_valid  (vec_valid),
    .vec_ready  (vec_ready),
    .vec_in_flat(vec_in_flat),
    .elem_valid (elem_valid),
    .elem_ready (elem_ready),
    .elem_data  (elem_data),
    .elem_idx   (elem_idx),
    .elem_last  (elem_last),
    .busy       (busy)
`ifdef DBD_VEC_COUNT_EN
    ,
    .vec_count  (vec_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  // Monitor: each presented element is compared to the scoreboard head.
  always @(negedge clk) begin
    if (!rst && elem_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_elem: got data %0d idx %0d, expected none", elem_data, elem_idx);
      end else begin
        front = exp_q[0];
        check("elem_data", int'(elem_data), int'(front.d));
        check("elem_idx",  int'(elem_idx),  int'(front.idx));
        check("elem_last", int'(elem_last), int'(front.last));
        if (elem_ready) begin
          void'(exp_q.pop_front());
          xfer_edges.push_back(cyc + 1);
        end
      end
    end
  end

  task automatic send_vec(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    bit ok;
    ok = 1'b0;
    exp_q.push_back(exp_t'{d: a, idx: 2'd0, last: 1'b0});
    exp_q.push_back(exp_t'{d: b, idx: 2'd1, last: 1'b0});
    exp_q.push_back(exp_t'{d: c, idx: 2'd2, last: 1'b1});
    vec_in_flat = {c, b, a};
    vec_valid   = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (vec_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("vec_accept");
    @(posedge clk);
    #1;
    cap_edge  = cyc;
    vec_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 200; t++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !busy && !elem_valid) break;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic wait_idx1();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(posedge clk);
      #1;
      if (elem_valid && elem_idx == 2'd1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("wait_idx1");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    vec_valid   = 1'b0;
    vec_in_flat = '0;
    elem_ready  = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_vec_ready",  vec_ready,  1);
    check("rst_elem_valid", elem_valid, 0);
    check("rst_busy",       busy,       0);
    check("rst_elem_data",  elem_data,  0);
    check("rst_elem_idx",   elem_idx,   0);
    check("rst_elem_last",  elem_last,  0);
`ifdef DBD_VEC_COUNT_EN
    check("rst_vec_count",  vec_count,  0);
`endif
    rst = 1'b0;

    // Single vector at full rate
    xfer_edges.delete();
    send_vec(8'd10, 8'd20, 8'd30);
    wait_drain();
    check("t2_xfers", xfer_edges.size(), 3);
    if (xfer_edges.size() == 3) begin
      check("t2_gap01", xfer_edges[1] - xfer_edges[0], 1);
      check("t2_gap12", xfer_edges[2] - xfer_edges[1], 1);
    end

    // Back-to-back vectors, then a third held until the bank frees
    xfer_edges.delete();
    send_vec(8'd10, 8'd20, 8'd30);
    send_vec(8'd40, 8'd50, 8'd60);
    check("t3_vec_ready_both_full", vec_ready, 0);
    check("t3_busy_both_full",      busy,      1);
    send_vec(8'd70, 8'd80, 8'd90);
    c3 = cap_edge;
    wait_drain();
    check("t3_xfers", xfer_edges.size(), 9);
    if (xfer_edges.size() == 9) begin
      for (int i = 1; i < 6; i++) check("t3_no_gap", xfer_edges[i] - xfer_edges[i-1], 1);
      check("t5_third_accept_edge", c3, xfer_edges[2] + 1);
    end

    // Stall at idx 1
    xfer_edges.delete();
    send_vec(8'd10, 8'd20, 8'd30);
    wait_idx1();
    elem_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t4_hold_data", elem_data, 20);
    check("t4_hold_idx",  elem_idx,  1);
    elem_ready = 1'b1;
    wait_drain();
    check("t4_xfers", xfer_edges.size(), 3);
    if (xfer_edges.size() == 3) check("t4_resume_gap", xfer_edges[2] - xfer_edges[1], 1);
`ifdef DBD_VEC_COUNT_EN
    check("vec_count_pre_rst", vec_count, 5);
`endif

    // Reset mid-stream
    send_vec(8'd40, 8'd50, 8'd60);
    wait_idx1();
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t6_elem_valid", elem_valid, 0);
    check("t6_busy",       busy,       0);
    check("t6_vec_ready",  vec_ready,  1);
    check("t6_elem_idx",   elem_idx,   0);
`ifdef DBD_VEC_COUNT_EN
    check("t6_vec_count_rst", vec_count, 0);
`endif
    xfer_edges.delete();
    send_vec(8'd1, 8'd2, 8'd3);
    wait_drain();
    check("t6_xfers", xfer_edges.size(), 3);
`ifdef DBD_VEC_COUNT_EN
    check("t6_vec_count", vec_count, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
